// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller.
// Looks at the decode-stage operands and at the EX-stage controls that leave
// the ID/EX register. Drives stall, flush and bubble requests into the PC,
// IF/ID and ID/EX registers, and selects the EX operand forwarding sources
// from a local shadow of the MEM and WB destination registers. Load-use stalls
// and taken-branch flushes are counted in saturating counters.
module id_ex_hazard_ctrl #(
  parameter int unsigned BR_FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic             ex_reg_w_ctrl,
  input  logic             ex_mem_read_ctrl,
  input  logic             ex_branch_taken,
  output logic             pc_stall,
  output logic             if2id_stall,
  output logic             if2id_flush,
  output logic             id2ex_bubble,
  output logic [1:0]       fwdA_sel,
  output logic [1:0]       fwdB_sel,
  output logic [CNT_W-1:0] ld_stall_cnt,
  output logic [CNT_W-1:0] br_flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [2:0]       FLUSH_LOAD = 3'(BR_FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;

  logic [4:0]       mem_rd_q;
  logic             mem_wen_n_q;
  logic             mem_ld_q;
  logic [4:0]       wb_rd_q;
  logic             wb_wen_n_q;

  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;

  logic             lu;
  logic             ld_inc;
  logic             br_inc;
  logic [1:0]       fwd_a_raw;
  logic [1:0]       fwd_b_raw;

  // Forwarding source for one EX operand; MEM wins over WB, loads in MEM
  // have no data yet, and x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] m_rd,
    input logic       m_wen_n,
    input logic       m_ld,
    input logic [4:0] w_rd,
    input logic       w_wen_n
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (!m_wen_n && (m_rd != 5'd0) && !m_ld && (m_rd == rs)) begin
      sel = SEL_MEM;
    end else if (!w_wen_n && (w_rd != 5'd0) && (w_rd == rs)) begin
      sel = SEL_WB;
    end
    return sel;
  endfunction

  // Shadow of the EX/MEM and MEM/WB destination fields; EX/MEM never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_q    <= '0;
      mem_wen_n_q <= 1'b1;
      mem_ld_q    <= 1'b0;
      wb_rd_q     <= '0;
      wb_wen_n_q  <= 1'b1;
    end else begin
      mem_rd_q    <= ex_rd;
      mem_wen_n_q <= ex_reg_w_ctrl;
      mem_ld_q    <= ex_mem_read_ctrl;
      wb_rd_q     <= mem_rd_q;
      wb_wen_n_q  <= mem_wen_n_q;
    end
  end

  // Hazard FSM state and flush-length counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q <= '0;
      br_cnt_q <= '0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      br_cnt_q <= br_cnt_d;
    end
  end

  // Load-use hazard: the load in EX writes a register the decode stage reads.
  always_comb begin
    lu = 1'b0;
    if (ex_mem_read_ctrl && !ex_reg_w_ctrl && (ex_rd != 5'd0) && id_valid) begin
      lu = (id_uses_rs1 && (id_rs1 == ex_rd)) ||
           (id_uses_rs2 && (id_rs2 == ex_rd));
    end
  end

  // Operand forwarding selects from the shadow pipeline.
  always_comb begin
    fwd_a_raw = fwd_sel(ex_rs1, mem_rd_q, mem_wen_n_q, mem_ld_q, wb_rd_q, wb_wen_n_q);
    fwd_b_raw = fwd_sel(ex_rs2, mem_rd_q, mem_wen_n_q, mem_ld_q, wb_rd_q, wb_wen_n_q);
    fwdA_sel  = rst_n ? fwd_a_raw : SEL_RF;
    fwdB_sel  = rst_n ? fwd_b_raw : SEL_RF;
  end

  // Next state and pipeline control requests; a taken branch overrides any
  // load-use stall, and reset forces a bubble with every other request low.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    pc_stall     = 1'b0;
    if2id_stall  = 1'b0;
    if2id_flush  = 1'b0;
    id2ex_bubble = 1'b0;
    ld_inc       = 1'b0;
    br_inc       = 1'b0;

    if (ex_branch_taken) begin
      if2id_flush  = 1'b1;
      id2ex_bubble = 1'b1;
      br_inc       = 1'b1;
      fcnt_d       = FLUSH_LOAD;
      state_d      = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu) begin
            pc_stall     = 1'b1;
            if2id_stall  = 1'b1;
            id2ex_bubble = 1'b1;
            ld_inc       = 1'b1;
            state_d      = STALL;
          end
        end
        STALL: begin
          state_d = RUN;
        end
        FLUSH: begin
          if2id_flush  = 1'b1;
          id2ex_bubble = 1'b1;
          fcnt_d       = (fcnt_q != 3'd0) ? fcnt_q - 3'd1 : 3'd0;
          if (fcnt_q <= 3'd1) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    if (!rst_n) begin
      pc_stall     = 1'b0;
      if2id_stall  = 1'b0;
      if2id_flush  = 1'b0;
      id2ex_bubble = 1'b1;
      ld_inc       = 1'b0;
      br_inc       = 1'b0;
    end
  end

  // Counter increments stop at all-ones.
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    br_cnt_d = br_cnt_q;
    if (ld_inc && (ld_cnt_q != '1)) begin
      ld_cnt_d = ld_cnt_q + CNT_ONE;
    end
    if (br_inc && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + CNT_ONE;
    end
  end

  assign ld_stall_cnt = ld_cnt_q;
  assign br_flush_cnt = br_cnt_q;

endmodule

// File: doc/id_ex_hazard_ctrl.md
Name: id_ex_hazard_ctrl

Overview:
Control-side counterpart of the ID/EX pipeline register. It observes the decode-stage operands and the EX-stage controls that leave the ID/EX register, then drives stall, flush and bubble requests back into the PC, IF/ID and ID/EX registers. It also selects the forwarding sources for the EX operands, using an internal shadow of the MEM and WB destination registers. Hazard events are counted for performance debugging.

Parameters:
BR_FLUSH_CYCLES, 2, number of consecutive cycles if2id_flush is asserted per taken branch/jump (1..7)
CNT_W, 16, width of the saturating event counters

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_rs1  in  5  decode-stage source register 1
id_rs2  in  5  decode-stage source register 2
id_uses_rs1  in  1  decode instruction reads rs1
id_uses_rs2  in  1  decode instruction reads rs2
ex_rd  in  5  rd at the ID/EX output
ex_rs1  in  5  rs1 at the ID/EX output
ex_rs2  in  5  rs2 at the ID/EX output
ex_reg_w_ctrl  in  1  EX register write, active low (0 = write)
ex_mem_read_ctrl  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch, or a jump/jalr; single-cycle pulse
pc_stall  out  1  hold PC
if2id_stall  out  1  hold IF/ID
if2id_flush  out  1  zero IF/ID
id2ex_bubble  out  1  load an all-zero-control bubble into ID/EX; reg_w_ctrl is forced to 1
fwdA_sel  out  2  EX operand A source: 00 = regfile, 01 = MEM, 10 = WB
fwdB_sel  out  2  EX operand B source, same encoding as fwdA_sel
ld_stall_cnt  out  CNT_W  load-use stalls taken, saturating
br_flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Reset, asynchronous on rst_n low:
  - FSM returns to RUN; flush counter, shadow registers and event counters clear.
  - Shadow wen_n values reset to 1.
  - While rst_n is low: id2ex_bubble=1; pc_stall, if2id_stall and if2id_flush are 0; fwd selects are 00.
  - Reset mid-flush or mid-stall abandons the sequence. No request persists after release.
- Shadow pipeline: every rising edge, unconditionally:
  - mem_rd, mem_wen_n and mem_ld capture ex_rd, ex_reg_w_ctrl and ex_mem_read_ctrl.
  - wb_rd and wb_wen_n capture mem_rd and mem_wen_n.
  - EX/MEM is never stalled.
- Forwarding, combinational:
  - fwdA_sel=01 if mem_wen_n=0, mem_rd!=0, mem_ld=0 and mem_rd==ex_rs1.
  - Otherwise fwdA_sel=10 if wb_wen_n=0, wb_rd!=0 and wb_rd==ex_rs1.
  - Otherwise 00. fwdB_sel follows the same rules using ex_rs2.
  - MEM has priority over WB. x0 is never forwarded.
- Load-use detection (lu): ex_mem_read_ctrl=1, ex_reg_w_ctrl=0, ex_rd!=0, id_valid=1, and either (id_uses_rs1 with id_rs1==ex_rd) or (id_uses_rs2 with id_rs2==ex_rd).
- FSM states RUN, STALL, FLUSH:
  - RUN, lu=1, no branch: pc_stall=if2id_stall=id2ex_bubble=1 in the same cycle. Next state STALL; ld_stall_cnt +1.
  - STALL: lasts exactly one cycle. lu detection is masked because the bubble now occupies EX. No stall outputs. Next state RUN, or FLUSH if a branch arrives.
  - ex_branch_taken=1 in any state: if2id_flush=1 and id2ex_bubble=1 in the same cycle; pc_stall and if2id_stall are forced to 0, so the branch beats the load-use stall. Flush counter loads BR_FLUSH_CYCLES-1; next state FLUSH if the loaded value is >0, else RUN; br_flush_cnt +1. The lu stall is dropped and ld_stall_cnt is not incremented.
  - FLUSH: if2id_flush=1 and id2ex_bubble=1; counter decrements and the FSM leaves to RUN when it reaches 0. lu is masked. A new ex_branch_taken reloads the counter and increments br_flush_cnt.
- Event counters saturate at all-ones and never wrap.
- All control outputs are combinational from state and inputs. Only the counters and shadow registers are flopped.

Test Plan:
- Reset release with no hazards, ex_reg_w_ctrl=1 → all stall/flush outputs 0, fwd selects 00, counters 0 for 10 cycles.
- ALU chain: EX writes x5 (ex_rd=5, ex_reg_w_ctrl=0); next cycle ex_rs1=5; the cycle after that ex_rs2=5 → fwdA_sel=01, then fwdB_sel=10. Repeat with rd=0 → selects stay 00.
- Load-use: ex_rd=7 load, id_rs2=7, id_uses_rs2=1 → exactly one cycle of pc_stall/if2id_stall/id2ex_bubble; next cycle no stall; ld_stall_cnt=1; after 2 cycles fwdB_sel=10 for ex_rs2=7.
- Branch taken with BR_FLUSH_CYCLES=2 → if2id_flush high for 2 cycles and id2ex_bubble for 2; br_flush_cnt=1. Same-cycle load-use plus branch → pc_stall=0, ld_stall_cnt unchanged.
- Branch in the 2nd FLUSH cycle → flush extends 2 cycles from the new pulse; br_flush_cnt=2. rst_n low mid-FLUSH → immediate id2ex_bubble=1, flush=0; after release, FSM is in RUN.
- CNT_W=4, 17 load-use events → ld_stall_cnt saturates at 15.
